// File: rtl/tx_fdt_scheduler_pkg.sv
// Shared ISO/IEC 14443-3 type A timing constants and FDT scheduler state type.
package iso14443a_pkg;

    localparam int unsigned BIT_TICKS      = 128;
    localparam logic [15:0] FDT_LAST_BIT_0 = 16'd1172;
    localparam logic [15:0] FDT_LAST_BIT_1 = 16'd1236;
    localparam int unsigned TX_WDOG_TICKS  = 4096;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FDT,
        SLOT,
        GO,
        TX_ACTIVE
    } fdt_state_t;

    function automatic logic [15:0] fdt_for_last_bit(input logic last_bit);
        return last_bit ? FDT_LAST_BIT_1 : FDT_LAST_BIT_0;
    endfunction

endpackage

// File: rtl/tx_fdt_scheduler_if.sv
// rx/tx handshake bundle around the FDT scheduler; master is the scheduler side.
interface tx_fdt_scheduler_if;

    logic rx_eoc;
    logic rx_last_bit;
    logic rx_sof;
    logic tx_req;
    logic tx_busy;
    logic tx_go;
    logic window_open;
    logic fdt_timeout;

    modport master (
        input  rx_eoc, rx_last_bit, rx_sof, tx_req, tx_busy,
        output tx_go, window_open, fdt_timeout
    );

    modport slave (
        output rx_eoc, rx_last_bit, rx_sof, tx_req, tx_busy,
        input  tx_go, window_open, fdt_timeout
    );

endinterface

// File: rtl/tx_fdt_scheduler_slot_counter.sv
// Tick counter since the last PCD pause edge; flags the cycle before each FDT slot.
module fdt_slot_counter
    import iso14443a_pkg::*;
#(
    parameter int unsigned RX_DELAY  = 3,
    parameter int unsigned TX_DELAY  = 2,
    parameter int unsigned MAX_EXTRA = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic last_bit_i,
    input  logic run_i,
    output logic slot_next_o,
    output logic last_slot_o
);

    localparam int unsigned K_W = (MAX_EXTRA > 0) ? $clog2(MAX_EXTRA + 1) : 1;

    logic [15:0]    count_q, count_d;
    logic [15:0]    fdt_q, fdt_d;
    logic [6:0]     phase_q, phase_d;
    logic [K_W-1:0] k_q, k_d;
    logic           started_q, started_d;

    // Slot 0 is found by comparing against the latched FDT; later slots by the 128-tick phase.
    assign slot_next_o = started_q ? (phase_q == 7'(BIT_TICKS - 1))
                                   : (count_q == fdt_q - 16'(TX_DELAY + 1));
    assign last_slot_o = (k_q == K_W'(MAX_EXTRA));

    always_comb begin
        count_d   = count_q;
        fdt_d     = fdt_q;
        phase_d   = phase_q;
        k_d       = k_q;
        started_d = started_q;
        if (load_i) begin
            count_d   = 16'(RX_DELAY);
            fdt_d     = fdt_for_last_bit(last_bit_i);
            phase_d   = '0;
            k_d       = '0;
            started_d = 1'b0;
        end else if (run_i) begin
            count_d = count_q + 16'd1;
            if (slot_next_o) begin
                started_d = 1'b1;
                phase_d   = '0;
                if (!last_slot_o) begin
                    k_d = k_q + 1'b1;
                end
            end else begin
                phase_d = phase_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            fdt_q     <= '0;
            phase_q   <= '0;
            k_q       <= '0;
            started_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            fdt_q     <= fdt_d;
            phase_q   <= phase_d;
            k_q       <= k_d;
            started_q <= started_d;
        end
    end

endmodule

// File: rtl/tx_fdt_scheduler.sv
// Gates the tx start strobe onto the ISO 14443-3 FDT slot grid after each PCD frame.
module tx_fdt_scheduler
    import iso14443a_pkg::*;
#(
    parameter int unsigned RX_DELAY  = 3,
    parameter int unsigned TX_DELAY  = 2,
    parameter int unsigned MAX_EXTRA = 255
) (
    input logic               clk,
    input logic               rst_n,
    tx_fdt_scheduler_if.master bus
);

    localparam int unsigned WD_W = $clog2(TX_WDOG_TICKS);

    fdt_state_t      state_q, state_d;
    logic            fdt_timeout_q, fdt_timeout_d;
    logic            busy_seen_q, busy_seen_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            load;
    logic            window_open;
    logic            slot_next;
    logic            last_slot;

    assign window_open = (state_q == WAIT_FDT) || (state_q == SLOT);

    fdt_slot_counter #(
        .RX_DELAY  (RX_DELAY),
        .TX_DELAY  (TX_DELAY),
        .MAX_EXTRA (MAX_EXTRA)
    ) u_slot_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .last_bit_i  (bus.rx_last_bit),
        .run_i       (window_open),
        .slot_next_o (slot_next),
        .last_slot_o (last_slot)
    );

    always_comb begin
        state_d       = state_q;
        fdt_timeout_d = 1'b0;
        busy_seen_d   = busy_seen_q;
        wdog_d        = wdog_q;
        load          = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_eoc) begin
                    load    = 1'b1;
                    state_d = WAIT_FDT;
                end
            end
            WAIT_FDT, SLOT: begin
                if (bus.rx_eoc) begin
                    load    = 1'b1;
                    state_d = WAIT_FDT;
                end else if (bus.rx_sof) begin
                    state_d = IDLE;
                end else if (slot_next) begin
                    if (bus.tx_req) begin
                        state_d = GO;
                    end else if (last_slot) begin
                        fdt_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        state_d = SLOT;
                    end
                end
            end
            GO: begin
                busy_seen_d = 1'b0;
                wdog_d      = '0;
                state_d     = bus.rx_sof ? IDLE : TX_ACTIVE;
            end
            TX_ACTIVE: begin
                wdog_d = wdog_q + 1'b1;
                // A tx that never raises tx_busy must not lock the scheduler out forever.
                if (bus.tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q || (wdog_q == '1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fdt_timeout_q <= 1'b0;
            busy_seen_q   <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            fdt_timeout_q <= fdt_timeout_d;
            busy_seen_q   <= busy_seen_d;
            wdog_q        <= wdog_d;
        end
    end

    assign bus.tx_go       = (state_q == GO);
    assign bus.window_open = window_open;
    assign bus.fdt_timeout = fdt_timeout_q;

endmodule

// File: tb/tb_tx_fdt_scheduler.sv
// Directed bench for tx_fdt_scheduler with an event-level FDT grid model checked every cycle.
module tb_tx_fdt_scheduler;

    localparam int RXD  = 3;
    localparam int TXD  = 2;
    localparam int MAXX = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tx_fdt_scheduler_if ifc ();

    tx_fdt_scheduler #(
        .RX_DELAY  (RXD),
        .TX_DELAY  (TXD),
        .MAX_EXTRA (MAXX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit m_win = 0, m_txact = 0, m_seen = 0;
    int m_start = 0, m_fdt = 0;
    bit e_go = 0, e_win = 0, e_to = 0;

    int go_cnt = 0, go_cyc = 0, to_cnt = 0, to_cyc = 0, soc_cyc = 0, nobusy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: outputs follow from the time elapsed since the frame's pause edge and the slot grid.
    always @(posedge clk) begin
        bit go_n, to_n;
        int c, off;
        cyc++;
        go_n = 0;
        to_n = 0;
        if (!rst_n) begin
            m_win   = 0;
            m_txact = 0;
            m_seen  = 0;
        end else if (m_txact) begin
            if (ifc.tx_busy) m_seen = 1;
            else if (m_seen) m_txact = 0;
        end else if (e_go) begin
            m_txact = !ifc.rx_sof;
            m_seen  = 0;
        end else if (ifc.rx_eoc) begin
            m_win   = 1;
            m_start = cyc;
            m_fdt   = ifc.rx_last_bit ? 1236 : 1172;
        end else if (m_win && ifc.rx_sof) begin
            m_win = 0;
        end else if (m_win) begin
            c   = RXD + (cyc - m_start);
            off = c - (m_fdt - TXD);
            if (off >= 0 && off % 128 == 0) begin
                if (ifc.tx_req) begin
                    go_n  = 1;
                    m_win = 0;
                end else if (off / 128 == MAXX) begin
                    to_n  = 1;
                    m_win = 0;
                end
            end
        end
        e_go  = go_n;
        e_to  = to_n;
        e_win = m_win;
    end

    always @(negedge clk) begin
        chk("tx_go", ifc.tx_go, rst_n ? e_go : 1'b0);
        chk("window_open", ifc.window_open, rst_n ? e_win : 1'b0);
        chk("fdt_timeout", ifc.fdt_timeout, rst_n ? e_to : 1'b0);
        if (ifc.tx_go === 1'b1) begin
            go_cnt++;
            go_cyc = cyc;
        end
        if (ifc.fdt_timeout === 1'b1) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (rst_n && m_txact && !m_seen) begin
            nobusy++;
            chk("tx_busy_within_4096", nobusy < 4096, 1);
        end else begin
            nobusy = 0;
        end
    end

    // tx side: first modulation TX_DELAY ticks after tx_go, then a short busy burst.
    initial begin
        ifc.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.tx_go === 1'b1) begin
                repeat (TXD) @(posedge clk);
                #1 ifc.tx_busy = 1'b1;
                soc_cyc = cyc;
                repeat (20) @(posedge clk);
                #1 ifc.tx_busy = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_eoc(input bit lb, output int e0);
        ifc.rx_eoc      = 1'b1;
        ifc.rx_last_bit = lb;
        tick(1);
        ifc.rx_eoc      = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_go(input string name, input int budget);
        int  g0;
        bit  ok;
        g0 = go_cnt;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (go_cnt != g0) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0, g0, t0;
        bit ok;
        ifc.rx_eoc = 0; ifc.rx_last_bit = 0; ifc.rx_sof = 0; ifc.tx_req = 0;
        #2 rst_n = 1'b0;
        tick(3);
        chk("reset_tx_go", ifc.tx_go, 0);
        chk("reset_window_open", ifc.window_open, 0);
        chk("reset_fdt_timeout", ifc.fdt_timeout, 0);
        rst_n = 1'b1;
        tick(2);

        // last_bit=1, response ready early: n=9 slot
        ifc.tx_req = 1;
        pulse_eoc(1, e0);
        wait_go("t1_go_seen", 1400);
        chk("t1_go_delay", go_cyc - e0, 1231);
        ifc.tx_req = 0;
        tick(10);
        chk("t1_soc_from_pause", soc_cyc - (e0 - RXD), 1236);
        tick(30);

        // last_bit=0, response ready early
        ifc.tx_req = 1;
        pulse_eoc(0, e0);
        wait_go("t2_go_seen", 1400);
        chk("t2_go_delay", go_cyc - e0, 1167);
        ifc.tx_req = 0;
        chk("t2_window_closed", ifc.window_open, 0);
        tick(40);

        // response ready late: waits for slot k=1 at count 1362
        pulse_eoc(1, e0);
        tick(1300 - RXD);
        ifc.tx_req = 1;
        wait_go("t3_go_seen", 400);
        chk("t3_go_delay", go_cyc - e0, 1362 - RXD);
        ifc.tx_req = 0;
        tick(40);

        // new PCD frame at count 800 aborts the schedule
        ifc.tx_req = 1;
        pulse_eoc(1, e0);
        tick(800 - RXD);
        chk("t4_window_before_sof", ifc.window_open, 1);
        g0 = go_cnt;
        ifc.rx_sof = 1;
        tick(1);
        ifc.rx_sof = 0;
        tick(1500);
        chk("t4_no_go", go_cnt - g0, 0);
        chk("t4_window_closed", ifc.window_open, 0);
        ifc.tx_req = 0;
        tick(5);

        // no response: timeout after the last extra slot, then tx_req alone does nothing
        t0 = to_cnt;
        pulse_eoc(0, e0);
        ok = 0;
        for (int i = 0; i < 1600; i++) begin
            tick(1);
            if (to_cnt != t0) begin
                ok = 1;
                break;
            end
        end
        chk("t5_timeout_seen", ok, 1);
        chk("t5_timeout_delay", to_cyc - e0, 1172 + 256 - TXD - RXD);
        chk("t5_window_closed", ifc.window_open, 0);
        g0 = go_cnt;
        ifc.tx_req = 1;
        tick(2000);
        chk("t5_no_go_outside_window", go_cnt - g0, 0);
        ifc.tx_req = 0;
        tick(5);

        // reset mid-window, then normal scheduling
        pulse_eoc(1, e0);
        tick(1000 - RXD);
        chk("t6_window_before_reset", ifc.window_open, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_tx_go", ifc.tx_go, 0);
        chk("t6_reset_window_open", ifc.window_open, 0);
        chk("t6_reset_fdt_timeout", ifc.fdt_timeout, 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        ifc.tx_req = 1;
        pulse_eoc(1, e0);
        wait_go("t6_go_seen", 1400);
        chk("t6_go_delay", go_cyc - e0, 1231);
        ifc.tx_req = 0;
        tick(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
